// File: rtl/fft_mag_pkg.sv
// rtl/fft_mag_pkg.sv - shared widths, FSM encoding, beta shifts and bit-reverse helper for fft_mag_unit
package fft_mag_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 12;
  localparam int STAGE_W_DEF = 4;

  // min is scaled by 3/8 as (min >> 2) + (min >> 3)
  localparam int BETA_SH_A = 2;
  localparam int BETA_SH_B = 3;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // Reverses the low n bits of k; bits at or above n pass through unchanged.
  function automatic logic [31:0] bit_reverse(input logic [31:0] k, input int n);
    logic [31:0] r;
    r = k;
    for (int i = 0; i < 32; i++) begin
      if (i < n) r[5'(i)] = k[5'(n - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_mag_unit_if.sv
// rtl/fft_mag_unit_if.sv - FFT result read port and magnitude write port bundle
interface fft_mag_unit_if
  import fft_mag_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_ena;
  logic [2*DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0]   wr_addr;
  logic                wr_ena;
  logic [DATA_W-1:0]   wr_data;

  modport master (
    output rd_addr, rd_ena,
    input  rd_data,
    output wr_addr, wr_ena, wr_data
  );

  modport slave (
    input  rd_addr, rd_ena,
    output rd_data,
    input  wr_addr, wr_ena, wr_data
  );

endinterface

// File: rtl/fft_mag_approx.sv
// rtl/fft_mag_approx.sv - combinational max + 3/8 min magnitude with saturation
module fft_mag_approx
  import fft_mag_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] mx,
  input  logic [DATA_W-1:0] mn,
  output logic [DATA_W-1:0] m
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, mx} + {1'b0, mn >> BETA_SH_A} + {1'b0, mn >> BETA_SH_B};
  assign m   = sum[DATA_W] ? '1 : sum[DATA_W-1:0];

endmodule

// File: rtl/fft_mag_unit.sv
// rtl/fft_mag_unit.sv - bit-reversed read, 3-stage magnitude pipeline, natural-order write
// Optional peak tracking outputs are enabled by defining FFT_MAG_PEAK_EN.
module fft_mag_unit
  import fft_mag_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int STAGE_W = STAGE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena_mag,
  input  logic [STAGE_W-1:0] stage_number,
  input  logic [ADDR_W-1:0]  max_point_fft,
  fft_mag_unit_if.master     mem,
  output logic               busy,
  output logic               mag_done
`ifdef FFT_MAG_PEAK_EN
  ,
  output logic [ADDR_W-1:0]  peak_bin,
  output logic [DATA_W-1:0]  peak_mag
`endif
);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   k, n_q;
  logic [STAGE_W-1:0]  stage_q;
  logic                start;
  int                  stage_lim;

  logic                p1_v, p2_v, p3_v;
  logic [ADDR_W-1:0]   p1_k, p2_k, p3_k;
  logic [DATA_W-1:0]   a, b, mx, mn, m;

  function automatic logic [DATA_W-1:0] abs_u(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v) + DATA_W'(1) : v;
  endfunction

  assign start = (state == IDLE) && ena_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      n_q     <= '0;
      stage_q <= '0;
      p1_v    <= 1'b0;
      p2_v    <= 1'b0;
      p3_v    <= 1'b0;
      p1_k    <= '0;
      p2_k    <= '0;
      p3_k    <= '0;
      a       <= '0;
      b       <= '0;
      mx      <= '0;
      mn      <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        n_q     <= max_point_fft;
        stage_q <= stage_number;
        k       <= '0;
      end else if (state == READ) begin
        k <= k + ADDR_W'(1);
      end
      // C1 captures |re|,|im| from the returning read; C2 orders them
      p1_v <= (state == READ);
      p1_k <= k;
      p2_v <= p1_v;
      p2_k <= p1_k;
      a    <= abs_u(mem.rd_data[2*DATA_W-1:DATA_W]);
      b    <= abs_u(mem.rd_data[DATA_W-1:0]);
      p3_v <= p2_v;
      p3_k <= p2_k;
      mx   <= (a >= b) ? a : b;
      mn   <= (a >= b) ? b : a;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ena_mag) state_nx = (max_point_fft == '0) ? DONE : READ;
      READ:    if (k == n_q - ADDR_W'(1)) state_nx = DRAIN;
      DRAIN:   if (!p1_v && !p2_v) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stage_lim = (int'(stage_q) > ADDR_W) ? ADDR_W : int'(stage_q);
  end

  fft_mag_approx #(.DATA_W(DATA_W)) u_approx (
    .mx (mx),
    .mn (mn),
    .m  (m)
  );

  assign busy        = (state != IDLE);
  assign mag_done    = (state == DONE);
  assign mem.rd_ena  = (state == READ);
  assign mem.rd_addr = (state == READ) ? ADDR_W'(bit_reverse(32'(k), stage_lim)) : '0;
  assign mem.wr_ena  = p3_v;
  assign mem.wr_addr = p3_v ? p3_k : '0;
  assign mem.wr_data = p3_v ? m : '0;

`ifdef FFT_MAG_PEAK_EN
  // Bins arrive in natural order, so strict > keeps the lowest bin on ties
  always_ff @(posedge clk) begin
    if (rst || start) begin
      peak_bin <= '0;
      peak_mag <= '0;
    end else if (p3_v && (m > peak_mag)) begin
      peak_bin <= p3_k;
      peak_mag <= m;
    end
  end
`endif

endmodule
